// File: rtl/cr_ib_tlv_framer.sv
// cr_ib_tlv_framer: emits RQE, DATA (header + payload) and CQE TLVs for one command onto a 64-bit AXI4-S bus.
// Optional feature macro: CR_IB_TLV_FRAMER_CQE_LEN_EN puts the byte length and payload word count in CQE [63:32].
module cr_ib_tlv_framer #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_byte_len,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [63:0]      out_tdata,
  output logic [7:0]       out_tstrb,
  output logic [1:0]       out_tuser,
  output logic             out_tlast,
  output logic             frame_cnt_stb,
  output logic             bytes_cnt_stb,
  output logic [3:0]       bytes_cnt_amt,
  output logic             busy
);

  localparam logic [7:0] TLV_RQE  = 8'h01;
  localparam logic [7:0] TLV_DATA = 8'h02;
  localparam logic [7:0] TLV_CQE  = 8'h03;

  // The state names the next word to be loaded into the output register.
  // The RQE word is loaded directly on command accept so it appears the following cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DHDR,
    S_DPAY,
    S_CQE
  } state_e;

  state_e state_q, state_d;

  // Latched command context
  logic [2:0]  len_lo_q;
  logic [13:0] words_q;
  logic [12:0] rem_q;
  logic [7:0]  tag_q;

  // Output register stage and the description of the word it holds
  logic        tvalid_q;
  logic [63:0] tdata_q;
  logic [7:0]  tstrb_q;
  logic [1:0]  tuser_q;
  logic        tlast_q;
  logic        out_hdr_q;
  logic [3:0]  out_amt_q;

  logic        frame_stb_q;
  logic        bytes_stb_q;
  logic [3:0]  bytes_amt_q;

  // Word selected for the next load
  logic        ld_valid;
  logic [63:0] ld_data;
  logic [7:0]  ld_strb;
  logic [1:0]  ld_user;
  logic        ld_last;
  logic        ld_hdr;
  logic [3:0]  ld_amt;

  logic        load_en;
  logic        cmd_fire;
  logic        pay_fire;
  logic        xfer;
  logic [13:0] cmd_words;
  logic [7:0]  cmd_tag8;
  logic [31:0] cqe_hi;

  function automatic logic [63:0] word0(input logic [7:0]  typ,
                                        input logic [15:0] tlv_len,
                                        input logic [7:0]  tag,
                                        input logic [31:0] hi);
    return {hi, tag, tlv_len, typ};
  endfunction

  function automatic logic [7:0] last_strb(input logic [2:0] lo);
    return (lo == 3'd0) ? 8'hFF : 8'((9'h1 << lo) - 9'h1);
  endfunction

  assign load_en   = !tvalid_q || out_tready;
  assign xfer      = tvalid_q && out_tready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign pay_fire  = in_valid && in_ready;
  assign cmd_words = 14'((17'(cmd_byte_len) + 17'd7) >> 3);
  assign cmd_tag8  = 8'(cmd_tag);

`ifdef CR_IB_TLV_FRAMER_CQE_LEN_EN
  logic [15:0] len_q;
  logic [15:0] pay_cnt_q;

  // By the time the CQE loads, every loaded payload word has also been transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      pay_cnt_q <= '0;
    end else if (cmd_fire) begin
      len_q     <= cmd_byte_len;
      pay_cnt_q <= '0;
    end else if (pay_fire) begin
      pay_cnt_q <= pay_cnt_q + 16'd1;
    end
  end

  assign cqe_hi = {len_q, pay_cnt_q};
`else
  assign cqe_hi = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire) state_d = S_DHDR;
      S_DHDR: if (load_en) state_d = (words_q != 14'd0) ? S_DPAY : S_CQE;
      S_DPAY: if (load_en && in_valid && rem_q == 13'd0) state_d = S_CQE;
      S_CQE:  if (load_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_strb   = 8'hFF;
    ld_user   = 2'b00;
    ld_last   = 1'b0;
    ld_hdr    = 1'b0;
    ld_amt    = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = !tvalid_q;
        if (cmd_valid && !tvalid_q) begin
          ld_valid = 1'b1;
          ld_data  = word0(TLV_RQE, 16'd1, cmd_tag8, 32'h0);
          ld_user  = 2'b11;
        end
      end
      S_DHDR: begin
        ld_valid = 1'b1;
        ld_data  = word0(TLV_DATA, 16'(words_q) + 16'd1, tag_q, 32'h0);
        ld_user  = {words_q == 14'd0, 1'b1};
        ld_hdr   = 1'b1;
      end
      S_DPAY: begin
        in_ready = load_en;
        if (in_valid) begin
          ld_valid = 1'b1;
          ld_data  = in_data;
          if (rem_q == 13'd0) begin
            ld_strb = last_strb(len_lo_q);
            ld_user = 2'b10;
            ld_amt  = (len_lo_q == 3'd0) ? 4'd8 : {1'b0, len_lo_q};
          end else begin
            ld_amt  = 4'd8;
          end
        end
      end
      S_CQE: begin
        ld_valid = 1'b1;
        ld_data  = word0(TLV_CQE, 16'd1, tag_q, cqe_hi);
        ld_user  = 2'b11;
        ld_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // rem_q holds the payload words still to load minus one, so 8192 words fit in 13 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q <= '0;
      words_q  <= '0;
      tag_q    <= '0;
      rem_q    <= '0;
    end else begin
      if (cmd_fire) begin
        len_lo_q <= cmd_byte_len[2:0];
        words_q  <= cmd_words;
        tag_q    <= cmd_tag8;
      end
      if (state_q == S_DHDR && load_en) rem_q <= 13'(words_q - 14'd1);
      else if (pay_fire)                rem_q <= rem_q - 13'd1;
    end
  end

  // The output register only reloads once its current word has gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tstrb_q   <= '0;
      tuser_q   <= '0;
      tlast_q   <= 1'b0;
      out_hdr_q <= 1'b0;
      out_amt_q <= '0;
    end else if (load_en) begin
      tvalid_q  <= ld_valid;
      out_hdr_q <= ld_valid && ld_hdr;
      out_amt_q <= ld_valid ? ld_amt : 4'd0;
      if (ld_valid) begin
        tdata_q <= ld_data;
        tstrb_q <= ld_strb;
        tuser_q <= ld_user;
        tlast_q <= ld_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_stb_q <= 1'b0;
      bytes_stb_q <= 1'b0;
      bytes_amt_q <= '0;
    end else begin
      frame_stb_q <= xfer && out_hdr_q;
      bytes_stb_q <= xfer && (out_amt_q != 4'd0);
      if (xfer && out_amt_q != 4'd0) bytes_amt_q <= out_amt_q;
    end
  end

  assign out_tvalid    = tvalid_q;
  assign out_tdata     = tdata_q;
  assign out_tstrb     = tstrb_q;
  assign out_tuser     = tuser_q;
  assign out_tlast     = tlast_q;
  assign frame_cnt_stb = frame_stb_q;
  assign bytes_cnt_stb = bytes_stb_q;
  assign bytes_cnt_amt = bytes_amt_q;
  assign busy          = (state_q != S_IDLE) || tvalid_q;

endmodule
